// File: rtl/dif_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dif_result_fifo
// Purpose  : Registered output stage for a 6-bit ripple subtractor. It queues
//            the raw 7-bit results {borrow, dif[5:0]} through a valid/ready
//            handshake. It decodes sign, zero and magnitude for the head
//            entry, and keeps a saturating count of borrowed results.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            in_valid/in_ready - write handshake, in_dif = {borrow, dif}
//            out_valid/out_ready - read handshake for the head entry
//            out_dif/out_borrow/out_zero/out_mag - decoded head entry
//            count             - occupancy 0..DEPTH
//            borrow_cnt        - saturating count of accepted borrows
// Revision : 1.0 - initial release
// ============================================================================
module dif_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_dif,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_dif,
    output logic                       out_borrow,
    output logic                       out_zero,
    output logic [5:0]                 out_mag,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           borrow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    // Storage has no reset: every output is masked by out_valid.
    logic [6:0]       mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] borrow_cnt_q, borrow_cnt_d;

    logic             w_push;
    logic             w_pop;
    logic [6:0]       w_head;

    // Handshake status derives from registered count only.
    assign in_ready  = (count_q != C_FULL);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        borrow_cnt_d = borrow_cnt_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_push && in_dif[6] && (borrow_cnt_q != {CNT_W{1'b1}})) begin
            borrow_cnt_d = borrow_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            borrow_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            borrow_cnt_q <= borrow_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_dif;
        end
    end

    assign w_head = mem_q[rd_ptr_q];

    always_comb begin
        out_dif    = '0;
        out_borrow = 1'b0;
        out_zero   = 1'b0;
        out_mag    = '0;
        if (out_valid) begin
            out_dif    = w_head[5:0];
            out_borrow = w_head[6];
            // Two's-complement negate; the impossible 1_000000 yields 0.
            out_mag    = w_head[6] ? (~w_head[5:0] + 6'd1) : w_head[5:0];
            out_zero   = !w_head[6] && (w_head[5:0] == 6'd0);
        end
    end

    assign count      = count_q;
    assign borrow_cnt = borrow_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dif_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dif_result_fifo
// Purpose  : Scoreboard bench for dif_result_fifo. Accepted pushes are queued
//            as expected entries; the head of the queue is compared with the
//            decoded DUT outputs every cycle and popped on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dif_result_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_dif;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_dif;
    logic             out_borrow;
    logic             out_zero;
    logic [5:0]       out_mag;
    logic [2:0]       count;
    logic [CNT_W-1:0] borrow_cnt;

    dif_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dif     (in_dif),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dif    (out_dif),
        .out_borrow (out_borrow),
        .out_zero   (out_zero),
        .out_mag    (out_mag),
        .count      (count),
        .borrow_cnt (borrow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [6:0] sb [$];
    int         exp_bcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ref_mag(input logic [6:0] d);
        int v;
        if (d[6]) v = (64 - int'(d[5:0])) % 64;
        else      v = int'(d[5:0]);
        return 6'(v);
    endfunction

    // Inputs are already set (just after a rising edge). Check outputs at the
    // falling edge, then advance the model across the next rising edge.
    task automatic tick();
        logic do_push;
        logic do_pop;
        @(negedge clk);
        check("count", 32'(count), 32'(sb.size()));
        check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("borrow_cnt", 32'(borrow_cnt), 32'(exp_bcnt));
        if (sb.size() != 0) begin
            check("out_dif", 32'(out_dif), 32'(sb[0][5:0]));
            check("out_borrow", 32'(out_borrow), 32'(sb[0][6]));
            check("out_mag", 32'(out_mag), 32'(ref_mag(sb[0])));
            check("out_zero", 32'(out_zero), 32'(sb[0] == 7'd0));
        end else begin
            check("idle_out", 32'({out_dif, out_borrow, out_zero, out_mag}), 32'd0);
        end
        do_push = in_valid && (sb.size() < DEPTH);
        do_pop  = out_ready && (sb.size() > 0);
        @(posedge clk);
        if (do_pop) void'(sb.pop_front());
        if (do_push) begin
            sb.push_back(in_dif);
            if (in_dif[6] && exp_bcnt < 255) exp_bcnt++;
        end
        #1;
    endtask

    task automatic push_one(input logic [6:0] v);
        in_valid  = 1'b1;
        in_dif    = v;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_dif    = '0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_borrow_cnt", 32'(borrow_cnt), 32'd0);
        check("rst_out_mag", 32'(out_mag), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 5-3 then one-cycle latency check
        in_valid = 1'b1;
        in_dif   = 7'b0_000010;
        tick();
        in_valid = 1'b0;
        check("first_dif", 32'(out_dif), 32'd2);
        check("first_mag", 32'(out_mag), 32'd2);
        check("first_zero", 32'(out_zero), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // negative and zero results
        push_one(7'b1_111110);
        check("bcnt_after_neg", 32'(borrow_cnt), 32'd1);
        push_one(7'b1_000001);
        push_one(7'b0_000000);
        push_one(7'b1_000000);

        // fill to full, drop a fifth push, drain
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_dif   = 7'(i);
            tick();
        end
        in_valid = 1'b0;
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_dif   = 7'b1_001001;
        tick();
        in_valid = 1'b0;
        check("full_drop_count", 32'(count), 32'd4);
        check("full_drop_bcnt", 32'(borrow_cnt), 32'(exp_bcnt));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("drained", 32'(out_valid), 32'd0);

        // streaming with pointer wrap
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_dif = 7'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();

        // borrow counter saturation
        in_valid = 1'b1;
        in_dif   = 7'b1_000001;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick();
        check("sat_bcnt", 32'(borrow_cnt), 32'd255);
        tick();

        // mid-operation reset with three entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_dif   = 7'(10 + i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_bcnt", 32'(borrow_cnt), 32'd0);
        sb.delete();
        exp_bcnt = 0;
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_dif   = 7'b0_000111;
        tick();
        in_valid = 1'b0;
        check("post_rst_dif", 32'(out_dif), 32'd7);
        out_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
